// File: rtl/jk_register_bank.sv
// WIDTH-bit bank of JK flip-flops with parallel load, up/down count and shift modes.
// Mode decode and count-toggle generation live in the bank; each bit is a jk_bit cell.

module jk_bit #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       resetL,
  input  logic       ld,
  input  logic       ld_d,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       j,
  input  logic       k,
  input  logic       cnt_tgl,
  input  logic       shin,
  output logic       q
);

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      q <= RST_BIT;
    end else if (ld) begin
      q <= ld_d;
    end else if (en) begin
      case (mode)
        2'b00: begin
          case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
          endcase
        end
        2'b01:   if (cnt_tgl) q <= ~q;
        2'b10:   q <= shin;
        default: q <= q;
      endcase
    end
  end

endmodule

module jk_register_bank #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic             clk,
  input  logic             resetL,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             up,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qL,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST = RESET_VALUE[WIDTH-1:0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic cnt_tgl;
    logic shin;

    // Synchronous counter: a bit flips when every lower bit is 1 (up) or 0 (down).
    if (i == 0) begin : g_lsb
      assign cnt_tgl = 1'b1;
      assign shin    = sin;
    end else begin : g_upper
      assign cnt_tgl = up ? (&q[i-1:0]) : ~(|q[i-1:0]);
      assign shin    = q[i-1];
    end

    jk_bit #(.RST_BIT(RST[i])) u_bit (
      .clk     (clk),
      .resetL  (resetL),
      .ld      (load),
      .ld_d    (d[i]),
      .en      (en),
      .mode    (mode),
      .j       (j[i]),
      .k       (k[i]),
      .cnt_tgl (cnt_tgl),
      .shin    (shin),
      .q       (q[i])
    );
  end

  assign qL = ~q;

  // tc is exactly the condition under which this edge wraps, so wrap is tc delayed.
  assign tc = en & ~load & (mode == 2'b01) & (up ? (&q) : ~(|q));

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) wrap <= 1'b0;
    else         wrap <= tc;
  end

endmodule
